// File: rtl/stamp_fifo.sv
// Capture-event detector feeding a first-word-fall-through FIFO with a saturating drop counter.
// Optional macro STAMP_DELTA_EN pushes the period between captures instead of the raw word.
module stamp_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 3,
  parameter int OVF_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      cap_value,
  input  logic                  cap_strobe,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic [OVF_BITS-1:0]   ovf_count,
  input  logic                  ovf_clear
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic                  strobe_q, strobe_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [OVF_BITS-1:0]   ovf_q, ovf_d;
  logic [WIDTH-1:0]      mem [DEPTH];

  logic                  cap_event;
  logic                  push_req;
  logic                  push_acc;
  logic                  drop;
  logic                  pop;
  logic                  full;
  logic [WIDTH-1:0]      push_word;

`ifdef STAMP_DELTA_EN
  logic [WIDTH-1:0]      prev_value_q, prev_value_d;
  logic                  primed_q, primed_d;

  // The very first capture has no predecessor, so it only primes the reference.
  always_comb begin
    prev_value_d = prev_value_q;
    primed_d     = primed_q;
    if (cap_event) begin
      prev_value_d = cap_value;
      primed_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_value_q <= '0;
      primed_q     <= 1'b0;
    end else begin
      prev_value_q <= prev_value_d;
      primed_q     <= primed_d;
    end
  end

  assign push_word = cap_value - prev_value_q;
  assign push_req  = cap_event & primed_q;
`else
  assign push_word = cap_value;
  assign push_req  = cap_event;
`endif

  assign cap_event = cap_strobe & ~strobe_q;
  assign rd_valid  = (level_q != '0);
  assign full      = (level_q == LVL_FULL);
  assign pop       = rd_valid & rd_ready;
  // A pop frees the head slot on the same edge, so a full FIFO can still accept.
  assign push_acc  = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  assign rd_data   = rd_valid ? mem[rd_ptr_q] : '0;
  assign level     = level_q;
  assign ovf_count = ovf_q;

  always_comb begin
    strobe_d = cap_strobe;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (push_acc) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);

    if (push_acc && !pop)      level_d = level_q + (DEPTH_LOG2 + 1)'(1);
    else if (!push_acc && pop) level_d = level_q - (DEPTH_LOG2 + 1)'(1);

    // Clear wins over a coincident drop; that drop goes uncounted.
    if (ovf_clear)                ovf_d = '0;
    else if (drop && ovf_q != '1) ovf_d = ovf_q + OVF_BITS'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
    end else begin
      strobe_q <= strobe_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q] <= push_word;
  end

endmodule
